// File: rtl/midi_floppy_pkg.sv
// midi_floppy_pkg: MIDI message constants and the note half-period table generator
package midi_floppy_pkg;
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON = 4'h9;
   localparam logic [3:0] CC = 4'hB;
   localparam logic [6:0] CC_SOUND_OFF = 7'd120;
   localparam logic [6:0] CC_NOTES_OFF = 7'd123;
   // Half-period in clk cycles of MIDI note k (octave -1, C..B), rounded to nearest
   function automatic int base_period(input int clk_rate, input int k);
      real r;
      case (k)
         0: r = 1.0;
         1: r = 1.0594630943592953;
         2: r = 1.122462048309373;
         3: r = 1.189207115002721;
         4: r = 1.2599210498948732;
         5: r = 1.3348398541700344;
         6: r = 1.4142135623730951;
         7: r = 1.4983070768766815;
         8: r = 1.5874010519681994;
         9: r = 1.681792830507429;
         10: r = 1.7817974362806785;
         default: r = 1.8877486253633868;
      endcase
      return $rtoi($itor(clk_rate) / (2.0 * 8.175799 * r) + 0.5);
   endfunction
endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial receiver with glitch-rejecting start check and mid-bit sampling
module midi_uart_rx #(
   parameter int CLK_RATE = 50000000,
   parameter int BAUD = 31250
) (
   input logic clk,
   input logic rst,
   input logic rx,
   output logic byte_valid,
   output logic [7:0] data,
   output logic rx_err
);
   localparam int BIT = CLK_RATE / BAUD;
   localparam int CW = $clog2(BIT + 1);
   localparam logic [CW-1:0] BIT_END = CW'(BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(BIT / 2 - 1);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
   logic [1:0] state;
   logic [2:0] sync;
   logic [CW-1:0] cnt;
   logic [2:0] bit_i;
   logic rx_s, fall;
   assign rx_s = sync[1];
   assign fall = sync[2] & ~sync[1];
   // Synchronise the pin, then walk start/data/stop sampling each bit at its centre
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sync <= 3'b111;
         cnt <= '0;
         bit_i <= '0;
         data <= '0;
         byte_valid <= 1'b0;
         rx_err <= 1'b0;
      end else begin
         sync <= {sync[1:0], rx};
         byte_valid <= 1'b0;
         rx_err <= 1'b0;
         cnt <= cnt + 1'b1;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (fall) state <= START;
            end
            START: if (cnt == HALF_END) begin
               cnt <= '0;
               bit_i <= '0;
               state <= rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_END) begin
               cnt <= '0;
               data <= {rx_s, data[7:1]};
               bit_i <= bit_i + 1'b1;
               if (bit_i == 3'd7) state <= STOP;
            end
            default: if (cnt == BIT_END) begin
               state <= IDLE;
               byte_valid <= rx_s;
               rx_err <= ~rx_s;
            end
         endcase
      end
   end
endmodule

// File: rtl/midi_floppy_ctrl.sv
// midi_floppy_ctrl: MIDI note decoder driving per-floppy enable and half-period setpoints
module midi_floppy_ctrl import midi_floppy_pkg::*; #(
   parameter int CLK_RATE = 50000000,
   parameter int BAUD = 31250,
   parameter int NUM_DRIVES = 6,
   parameter int SP_W = 22
) (
   input logic clk,
   input logic rst,
   input logic midi_rx,
   output logic [NUM_DRIVES*SP_W-1:0] floppy_sp,
   output logic [NUM_DRIVES-1:0] floppy_en,
   output logic rx_err,
   output logic activity
);
   logic byte_valid;
   logic [7:0] rx_data;
   logic [SP_W-1:0] base_tab [12];
   logic [7:0] status;
   logic cnt;
   logic [6:0] d1;
   logic busy;
   logic [3:0] calc_ch, oct;
   logic [6:0] rem, calc_note;
   logic [6:0] cur_note [NUM_DRIVES];
   logic [3:0] typ, ch;
   logic one_byte, act, note_on, note_off, all_off;
   midi_uart_rx #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) u_rx (
      .clk(clk),
      .rst(rst),
      .rx(midi_rx),
      .byte_valid(byte_valid),
      .data(rx_data),
      .rx_err(rx_err)
   );
   assign activity = byte_valid;
   for (genvar k = 0; k < 12; k++) begin : g_base
      assign base_tab[k] = SP_W'(base_period(CLK_RATE, k));
   end
   assign typ = status[3+4:4];
   assign ch = status[3:0];
   assign one_byte = typ == 4'hC || typ == 4'hD;
   assign act = byte_valid & ~rx_data[7] & status[7] & cnt & ({1'b0, ch} < 5'(NUM_DRIVES));
   assign note_on = typ == NOTE_ON && rx_data[6:0] != 7'd0;
   assign note_off = typ == NOTE_OFF || typ == NOTE_ON;
   assign all_off = typ == CC && (d1 == CC_SOUND_OFF || d1 == CC_NOTES_OFF);
   // Parse bytes with running status, then reduce the note to octave/semitone one step per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         status <= '0;
         cnt <= 1'b0;
         d1 <= '0;
         busy <= 1'b0;
         calc_ch <= '0;
         oct <= '0;
         rem <= '0;
         calc_note <= '0;
         floppy_sp <= '0;
         floppy_en <= '0;
         for (int i = 0; i < NUM_DRIVES; i++) cur_note[i] <= '0;
      end else begin
         if (byte_valid && rx_data[7] && rx_data[7:3] != 5'b11111) begin
            status <= rx_data[7:4] == 4'hF ? 8'h00 : rx_data;
            cnt <= 1'b0;
         end else if (byte_valid && !rx_data[7] && status[7]) begin
            if (!cnt) d1 <= rx_data[6:0];
            cnt <= !cnt && !one_byte;
         end
         if (act && note_on) begin
            busy <= 1'b1;
            calc_ch <= ch;
            calc_note <= d1;
            rem <= d1;
            oct <= '0;
         end else if (busy) begin
            busy <= rem >= 7'd12;
            rem <= rem >= 7'd12 ? rem - 7'd12 : rem;
            oct <= rem >= 7'd12 ? oct + 4'd1 : oct;
         end
         for (int i = 0; i < NUM_DRIVES; i++) begin
            if (busy && rem < 7'd12 && calc_ch == 4'(i)) begin
               floppy_sp[i*SP_W +: SP_W] <= base_tab[rem[3:0]] >> oct;
               floppy_en[i] <= 1'b1;
               cur_note[i] <= calc_note;
            end
            if (act && ch == 4'(i) && !note_on && ((note_off && d1 == cur_note[i]) || all_off))
               floppy_en[i] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_midi_floppy_ctrl.sv
// tb_midi_floppy_ctrl: directed and randomized MIDI streams checked against a message-level model
module tb_midi_floppy_ctrl;
   localparam int CLK_RATE = 50_000_000;
   localparam int BAUD = 3_125_000;
   localparam int ND = 6;
   localparam int SP_W = 22;
   localparam int BIT = CLK_RATE / BAUD;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic midi_rx = 1'b1;
   logic [ND*SP_W-1:0] floppy_sp;
   logic [ND-1:0] floppy_en;
   logic rx_err, activity;
   int errors = 0, checks = 0, act_cnt = 0, err_cnt = 0, missed = 0;
   int m_base [12];
   bit [ND-1:0] m_en;
   int m_sp [ND];
   int m_note [ND];
   int m_status, m_cnt, m_d1;

   midi_floppy_ctrl #(.CLK_RATE(CLK_RATE), .BAUD(BAUD), .NUM_DRIVES(ND), .SP_W(SP_W)) dut (
      .clk(clk),
      .rst(rst),
      .midi_rx(midi_rx),
      .floppy_sp(floppy_sp),
      .floppy_en(floppy_en),
      .rx_err(rx_err),
      .activity(activity)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (activity) act_cnt++;
      if (rx_err) err_cnt++;
   end

   function automatic void m_reset();
      m_en = '0;
      for (int i = 0; i < ND; i++) begin
         m_sp[i] = 0;
         m_note[i] = 0;
      end
      m_status = -1;
      m_cnt = 0;
      m_d1 = 0;
   endfunction

   // Message-level reference: byte classes, running status, then note semantics
   function automatic void m_byte(input logic [7:0] b);
      int v, ch, typ, need;
      v = int'(b);
      if (v >= 248) return;
      if (v >= 240) begin
         m_status = -1;
         return;
      end
      if (v >= 128) begin
         m_status = v;
         m_cnt = 0;
         return;
      end
      if (m_status < 0) return;
      typ = m_status / 16;
      ch = m_status % 16;
      need = (typ == 12 || typ == 13) ? 1 : 2;
      if (m_cnt == 0) begin
         m_d1 = v;
         m_cnt = need - 1;
         return;
      end
      m_cnt = 0;
      if (ch >= ND) return;
      if (typ == 9 && v > 0) begin
         m_note[ch] = m_d1;
         m_sp[ch] = m_base[m_d1 % 12] >> (m_d1 / 12);
         m_en[ch] = 1'b1;
      end else if ((typ == 8 || typ == 9) && m_d1 == m_note[ch]) m_en[ch] = 1'b0;
      else if (typ == 11 && (m_d1 == 120 || m_d1 == 123)) m_en[ch] = 1'b0;
   endfunction

   function automatic logic [ND*SP_W-1:0] model_sp();
      logic [ND*SP_W-1:0] v;
      for (int i = 0; i < ND; i++) v[i*SP_W +: SP_W] = SP_W'(m_sp[i]);
      return v;
   endfunction

   // Serialise one 8N1 frame; waits a bounded time for the receiver's pulse, then 15 more cycles
   task automatic send_byte(input logic [7:0] b, input bit bad);
      int a0, e0;
      bit seen;
      a0 = act_cnt;
      e0 = err_cnt;
      seen = 1'b0;
      midi_rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         midi_rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      midi_rx = ~bad;
      for (int i = 0; i < 2 * BIT && !seen; i++) begin
         @(negedge clk);
         seen = bad ? (err_cnt != e0) : (act_cnt != a0);
      end
      midi_rx = 1'b1;
      if (!seen) missed++;
      repeat (15) @(posedge clk);
      @(negedge clk);
      if (!bad) m_byte(b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (floppy_en !== '0) begin
         errors++;
         $display("FAIL reset_en got=%b want=0", floppy_en);
      end
      checks++;
      if (floppy_sp !== '0) begin
         errors++;
         $display("FAIL reset_sp got=%h want=0", floppy_sp);
      end
      checks++;
      if ({rx_err, activity} !== 2'b00) begin
         errors++;
         $display("FAIL reset_pulses got=%b want=00", {rx_err, activity});
      end
   endtask

   task automatic test_note_on();
      int m0;
      m0 = missed;
      send_byte(8'h90, 0);
      send_byte(8'h45, 0);
      send_byte(8'h64, 0);
      checks++;
      if (floppy_en !== 6'b000001) begin
         errors++;
         $display("FAIL note_on_en got=%b want=000001", floppy_en);
      end
      checks++;
      if (floppy_sp[0 +: SP_W] !== 22'd56818) begin
         errors++;
         $display("FAIL note_on_sp got=%0d want=56818", floppy_sp[0 +: SP_W]);
      end
      checks++;
      if (floppy_sp !== model_sp()) begin
         errors++;
         $display("FAIL note_on_all got=%h want=%h", floppy_sp, model_sp());
      end
      checks++;
      if (missed != m0) begin
         errors++;
         $display("FAIL note_on_frames missed=%0d want=0", missed - m0);
      end
   endtask

   task automatic test_running_status();
      send_byte(8'h91, 0);
      send_byte(8'h3C, 0);
      send_byte(8'h40, 0);
      checks++;
      if (floppy_sp[SP_W +: SP_W] !== 22'd95556) begin
         errors++;
         $display("FAIL running_first got=%0d want=95556", floppy_sp[SP_W +: SP_W]);
      end
      send_byte(8'h3E, 0);
      send_byte(8'h40, 0);
      checks++;
      if (floppy_sp[SP_W +: SP_W] !== SP_W'(m_base[2] >> 5)) begin
         errors++;
         $display("FAIL running_second got=%0d want=%0d", floppy_sp[SP_W +: SP_W], m_base[2] >> 5);
      end
      checks++;
      if (floppy_en[1] !== 1'b1) begin
         errors++;
         $display("FAIL running_en got=%b want=1", floppy_en[1]);
      end
   endtask

   task automatic test_note_off();
      send_byte(8'h92, 0);
      send_byte(8'h3C, 0);
      send_byte(8'h40, 0);
      send_byte(8'h82, 0);
      send_byte(8'h3E, 0);
      send_byte(8'h00, 0);
      checks++;
      if (floppy_en[2] !== 1'b1) begin
         errors++;
         $display("FAIL wrong_note_off got=%b want=1", floppy_en[2]);
      end
      send_byte(8'h92, 0);
      send_byte(8'h3C, 0);
      send_byte(8'h00, 0);
      checks++;
      if (floppy_en[2] !== 1'b0) begin
         errors++;
         $display("FAIL vel0_off_en got=%b want=0", floppy_en[2]);
      end
      checks++;
      if (floppy_sp[2*SP_W +: SP_W] !== 22'd95556) begin
         errors++;
         $display("FAIL vel0_off_sp got=%0d want=95556", floppy_sp[2*SP_W +: SP_W]);
      end
   endtask

   task automatic test_realtime();
      send_byte(8'h90, 0);
      send_byte(8'h40, 0);
      send_byte(8'hF8, 0);
      send_byte(8'h7F, 0);
      checks++;
      if (floppy_sp[0 +: SP_W] !== SP_W'(m_base[4] >> 5) || floppy_en[0] !== 1'b1) begin
         errors++;
         $display("FAIL realtime_note got sp=%0d en=%b want sp=%0d en=1",
                  floppy_sp[0 +: SP_W], floppy_en[0], m_base[4] >> 5);
      end
   endtask

   task automatic test_errors();
      int a0, e0;
      logic [ND-1:0] en0;
      logic [ND*SP_W-1:0] sp0;
      a0 = act_cnt;
      e0 = err_cnt;
      en0 = floppy_en;
      sp0 = floppy_sp;
      send_byte(8'h93, 1);
      checks++;
      if (err_cnt - e0 != 1 || act_cnt != a0) begin
         errors++;
         $display("FAIL bad_stop got err=%0d act=%0d want err=1 act=0", err_cnt - e0, act_cnt - a0);
      end
      send_byte(8'h97, 0);
      send_byte(8'h40, 0);
      send_byte(8'h40, 0);
      checks++;
      if (floppy_en !== en0 || floppy_sp !== sp0) begin
         errors++;
         $display("FAIL no_side_effect got en=%b sp=%h want en=%b sp=%h", floppy_en, floppy_sp, en0, sp0);
      end
      checks++;
      if (floppy_en !== m_en || floppy_sp !== model_sp()) begin
         errors++;
         $display("FAIL errors_model got en=%b want en=%b", floppy_en, m_en);
      end
   endtask

   task automatic test_all_notes_off();
      send_byte(8'h93, 0);
      send_byte(8'h40, 0);
      send_byte(8'h40, 0);
      checks++;
      if (floppy_en[3] !== 1'b1) begin
         errors++;
         $display("FAIL cc_pre_en got=%b want=1", floppy_en[3]);
      end
      send_byte(8'hB3, 0);
      send_byte(8'h7B, 0);
      send_byte(8'h00, 0);
      checks++;
      if (floppy_en !== m_en || floppy_en[3] !== 1'b0) begin
         errors++;
         $display("FAIL all_notes_off got=%b want=%b", floppy_en, m_en);
      end
   endtask

   task automatic test_rst_mid_frame();
      int a0;
      a0 = act_cnt;
      midi_rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         midi_rx = i[0];
         repeat (BIT) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      midi_rx = 1'b1;
      m_reset();
      repeat (3 * BIT) @(negedge clk);
      checks++;
      if (floppy_en !== '0 || floppy_sp !== '0 || act_cnt != a0) begin
         errors++;
         $display("FAIL rst_mid got en=%b sp=%h act=%0d want all 0", floppy_en, floppy_sp, act_cnt - a0);
      end
      send_byte(8'h94, 0);
      send_byte(8'h30, 0);
      send_byte(8'h50, 0);
      checks++;
      if (floppy_sp[4*SP_W +: SP_W] !== SP_W'(m_base[0] >> 4) || floppy_en !== 6'b010000) begin
         errors++;
         $display("FAIL rst_recover got sp=%0d en=%b want sp=%0d en=010000",
                  floppy_sp[4*SP_W +: SP_W], floppy_en, m_base[0] >> 4);
      end
   endtask

   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] st;
      int ch, kind, note;
      for (int n = 0; n < 40; n++) begin
         q = {};
         ch = $urandom_range(0, 7);
         kind = $urandom_range(0, 9);
         note = $urandom_range(0, 127);
         if (kind <= 4) begin
            st = 8'h90 | 8'(ch);
            q = {8'(note), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127))};
         end else if (kind <= 6) begin
            st = 8'h80 | 8'(ch);
            if (ch < ND && $urandom_range(0, 1) == 1) note = m_note[ch];
            q = {8'(note), 8'($urandom_range(0, 127))};
         end else if (kind == 7) begin
            st = 8'hB0 | 8'(ch);
            q = {($urandom_range(0, 2) == 0) ? 8'(note) : ($urandom_range(0, 1) == 1 ? 8'd120 : 8'd123), 8'h00};
         end else if (kind == 8) begin
            st = 8'hC0 | 8'(ch);
            q = {8'(note)};
         end else begin
            st = $urandom_range(0, 1) == 1 ? 8'hF8 : 8'hF0;
            q = {8'(note)};
         end
         if (!(kind <= 7 && int'(st) == m_status && $urandom_range(0, 1) == 1)) q.push_front(st);
         foreach (q[i]) send_byte(q[i], 0);
         checks++;
         if (floppy_en !== m_en) begin
            errors++;
            $display("FAIL random_en msg=%0d got=%b want=%b", n, floppy_en, m_en);
         end
         checks++;
         if (floppy_sp !== model_sp()) begin
            errors++;
            $display("FAIL random_sp msg=%0d got=%h want=%h", n, floppy_sp, model_sp());
         end
      end
      checks++;
      if (missed != 0) begin
         errors++;
         $display("FAIL frames_seen missed=%0d want=0", missed);
      end
   endtask

   initial begin
      for (int k = 0; k < 12; k++)
         m_base[k] = $rtoi(real'(CLK_RATE) / (2.0 * 8.175799 * 2.0 ** (real'(k) / 12.0)) + 0.5);
      m_reset();
      test_reset();
      test_note_on();
      test_running_status();
      test_note_off();
      test_realtime();
      test_errors();
      test_all_notes_off();
      test_rst_mid_frame();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
